// File: rtl/log_mover.sv
// log_mover: latches per-log start offsets, then moves each log once per frame.
// Logs are served one per clock through a single move/wrap path.
module log_mover #(
  parameter int NUM_OF_LOGS = 15,
  parameter int SCREEN_W    = 640
) (
  input  logic                         CLK,
  input  logic                         resetN,
  input  logic                         startOfFrame,
  input  logic                         load,
  input  logic                         pause,
  input  logic [NUM_OF_LOGS-1:0][8:0] start_offsetX,
  input  logic [NUM_OF_LOGS-1:0][8:0] start_offsetY,
  output logic [NUM_OF_LOGS-1:0][9:0] logX,
  output logic [NUM_OF_LOGS-1:0][9:0] logY,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    UPDATE
  } state_e;

  localparam logic [3:0]  LAST = 4'(NUM_OF_LOGS - 1);
  localparam logic [10:0] W11  = 11'(SCREEN_W);

  state_e                        state_q, state_d;
  logic [3:0]                    idx_q, idx_d;
  logic                          pend_q, pend_d;
  logic                          ovr_q, ovr_d;
  logic                          done_q, done_d;
  logic                          wr_en;
  logic [9:0]                    x_d, y_d;
  logic [NUM_OF_LOGS-1:0][9:0]   logx_q, logy_q;

  logic [10:0] cx;
  logic [10:0] step;
  logic [10:0] sum_r;
  logic [9:0]  rx, lx;

  assign cx    = {1'b0, logx_q[idx_q]};
  assign step  = {9'd0, idx_q[1:0]} + 11'd1;
  assign sum_r = cx + step;
  assign rx    = (sum_r >= W11) ? 10'(sum_r - W11) : sum_r[9:0];
  assign lx    = (cx < step) ? 10'(cx + W11 - step) : 10'(cx - step);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    x_d     = logx_q[idx_q];
    y_d     = logy_q[idx_q];
    unique case (state_q)
      IDLE: begin
        if (load || pend_q) begin
          state_d = LOAD;
          idx_d   = '0;
          pend_d  = 1'b0;
          ovr_d   = 1'b0;
        end else if (startOfFrame && !pause) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      LOAD, UPDATE: begin
        wr_en = 1'b1;
        if (state_q == LOAD) begin
          x_d = {1'b0, start_offsetX[idx_q]};
          y_d = {1'b0, start_offsetY[idx_q]};
        end else begin
          // even logs drift right, odd logs drift left
          x_d = idx_q[0] ? lx : rx;
        end
        if (startOfFrame) ovr_d = 1'b1;
        if (load) pend_d = 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
      logx_q  <= '0;
      logy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      done_q  <= done_d;
      if (wr_en) begin
        logx_q[idx_q] <= x_d;
        logy_q[idx_q] <= y_d;
      end
    end
  end

  assign logX    = logx_q;
  assign logY    = logy_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_log_mover.sv
// tb_log_mover: vector table, hand sequences and random passes
// checked against a frame-level position model.
module tb_log_mover;

  logic              CLK = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic              load;
  logic              pause;
  logic [14:0][8:0]  offx, offy;
  logic [14:0][9:0]  logX, logY;
  logic              busy, done, overrun;

  int checks = 0;
  int errors = 0;
  int mx[15];
  int my[15];

  always #5 CLK = ~CLK;

  log_mover #(.NUM_OF_LOGS(15), .SCREEN_W(640)) dut (
    .CLK(CLK),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .load(load),
    .pause(pause),
    .start_offsetX(offx),
    .start_offsetY(offy),
    .logX(logX),
    .logY(logY),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  typedef struct {
    int idx;
    int x0;
    int frames;
    int exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_load();
    for (int i = 0; i < 15; i++) begin
      mx[i] = int'(offx[i]);
      my[i] = int'(offy[i]);
    end
  endtask

  task automatic model_frame();
    for (int i = 0; i < 15; i++) begin
      int s;
      s = (i % 4) + 1;
      if (i % 2 == 0) mx[i] = (mx[i] + s) % 640;
      else            mx[i] = (mx[i] - s + 640) % 640;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("%s logX[%0d]", tag, i), int'(logX[i]), mx[i]);
      chk($sformatf("%s logY[%0d]", tag, i), int'(logY[i]), my[i]);
    end
  endtask

  task automatic rand_offsets();
    for (int i = 0; i < 15; i++) begin
      offx[i] = 9'($urandom_range(0, 511));
      offy[i] = 9'($urandom_range(0, 511));
    end
  endtask

  // pulse a request, then watch a fixed 20-cycle window
  task automatic run_pass(input bit do_load, input bit p,
                          output int bc, output int dc);
    pause = p;
    if (do_load) load = 1'b1;
    else         startOfFrame = 1'b1;
    tick();
    load = 1'b0;
    startOfFrame = 1'b0;
    bc = 0;
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      bc += int'(busy);
      dc += int'(done);
      tick();
    end
    pause = 1'b0;
  endtask

  initial begin
    int bc, dc;

    vecs[0] = '{0, 100, 1, 101};
    vecs[1] = '{1, 20, 1, 18};
    vecs[2] = '{2, 509, 44, 1};
    vecs[3] = '{3, 2, 1, 638};
    vecs[4] = '{0, 511, 129, 0};
    vecs[5] = '{1, 0, 1, 638};
    vecs[6] = '{4, 300, 5, 305};
    vecs[7] = '{7, 10, 3, 638};
    vecs[8] = '{14, 511, 50, 21};
    vecs[9] = '{13, 1, 1, 639};

    resetN = 1'b0;
    startOfFrame = 1'b0;
    load = 1'b0;
    pause = 1'b0;
    offx = '0;
    offy = '0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end
    compare_all("reset");
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset overrun", int'(overrun), 0);
    resetN = 1'b1;
    tick();

    // directed load
    rand_offsets();
    offx[0] = 9'd100;
    offy[0] = 9'd50;
    offx[1] = 9'd20;
    offx[14] = 9'd511;
    run_pass(1'b1, 1'b0, bc, dc);
    model_load();
    chk("load busy cycles", bc, 15);
    chk("load done pulses", dc, 1);
    chk("load logX0", int'(logX[0]), 100);
    chk("load logY0", int'(logY[0]), 50);
    chk("load logX14", int'(logX[14]), 511);
    compare_all("load");

    // move: log 1 lands one cycle after log 0
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("move busy at E0", int'(busy), 1);
    tick();
    chk("move logX0 at E0+1", int'(logX[0]), 101);
    chk("move logX1 at E0+1", int'(logX[1]), 20);
    tick();
    chk("move logX1 at E0+2", int'(logX[1]), 18);
    for (int i = 0; i < 18; i++) tick();
    model_frame();
    compare_all("move");

    // pause blocks a new pass
    run_pass(1'b0, 1'b1, bc, dc);
    chk("pause busy cycles", bc, 0);
    chk("pause done pulses", dc, 0);
    compare_all("pause");

    // load wins over a same-cycle startOfFrame
    rand_offsets();
    load = 1'b1;
    run_pass(1'b0, 1'b0, bc, dc);
    model_load();
    chk("prio busy cycles", bc, 15);
    chk("prio done pulses", dc, 1);
    chk("prio overrun", int'(overrun), 0);
    compare_all("prio");

    // overrun and deferred load during an update pass
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    tick();
    rand_offsets();
    startOfFrame = 1'b1;
    load = 1'b1;
    tick();
    startOfFrame = 1'b0;
    load = 1'b0;
    chk("ovr set", int'(overrun), 1);
    for (int i = 0; i < 11; i++) tick();
    chk("ovr busy E0+14", int'(busy), 1);
    tick();
    chk("ovr busy E0+15", int'(busy), 0);
    chk("ovr done E0+15", int'(done), 1);
    chk("ovr held E0+15", int'(overrun), 1);
    tick();
    chk("defer busy E0+16", int'(busy), 1);
    chk("defer done E0+16", int'(done), 0);
    chk("defer ovr cleared", int'(overrun), 0);
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      dc += int'(done);
      tick();
    end
    chk("defer done pulses", dc, 1);
    model_load();
    compare_all("defer");

    // table of wrap / speed / direction vectors
    foreach (vecs[v]) begin
      rand_offsets();
      offx[vecs[v].idx] = 9'(vecs[v].x0);
      run_pass(1'b1, 1'b0, bc, dc);
      model_load();
      for (int f = 0; f < vecs[v].frames; f++) begin
        run_pass(1'b0, 1'b0, bc, dc);
        model_frame();
      end
      chk($sformatf("vec%0d logX[%0d]", v, vecs[v].idx),
          int'(logX[vecs[v].idx]), vecs[v].exp);
      compare_all($sformatf("vec%0d", v));
    end

    // random loads, frames and paused frames
    for (int r = 0; r < 30; r++) begin
      int op;
      op = int'($urandom_range(0, 3));
      if (op == 0) begin
        rand_offsets();
        run_pass(1'b1, 1'b0, bc, dc);
        model_load();
      end else if (op == 1) begin
        run_pass(1'b0, 1'b1, bc, dc);
      end else begin
        run_pass(1'b0, 1'b0, bc, dc);
        model_frame();
      end
      chk($sformatf("rnd%0d done", r), dc, (op == 1) ? 0 : 1);
      compare_all($sformatf("rnd%0d", r));
    end

    // async reset in the middle of a pass
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    chk("pre-reset overrun", int'(overrun), 1);
    #2;
    resetN = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end
    compare_all("midreset");
    chk("midreset busy", int'(busy), 0);
    chk("midreset done", int'(done), 0);
    chk("midreset overrun", int'(overrun), 0);
    tick();
    resetN = 1'b1;
    tick();
    chk("post-reset busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/log_mover.md
# log_mover

Downstream consumer of the per-log random start offsets in the Frogger datapath. Latches the 15 start positions on a load request, then advances every log horizontally once per video frame with per-log speed and direction and screen wrap-around. Its registered per-log top-left coordinates feed the log drawing/collision logic. Logs are updated one per clock, time-multiplexed through a single adder.

## Interface
- NUM_OF_LOGS, 15, number of logs; fixed array size.
- SCREEN_W, 640, horizontal wrap modulus in pixels; must be > 511 + 4.

- CLK  in  1  system clock; all state on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse per frame; requests a movement pass.
- load  in  1  one-cycle pulse; requests reload of all positions from start offsets.
- pause  in  1  level; while high, startOfFrame is ignored.
- start_offsetX  in  [8:0] x NUM_OF_LOGS  initial X per log, 0..511.
- start_offsetY  in  [8:0] x NUM_OF_LOGS  Y per log, 0..511.
- logX  out  [9:0] x NUM_OF_LOGS  current top-left X, always 0..SCREEN_W-1.
- logY  out  [9:0] x NUM_OF_LOGS  top-left Y, zero-extended latched start_offsetY.
- busy  out  1  high while a LOAD or UPDATE pass is in progress.
- done  out  1  one-cycle pulse when a pass completes.
- overrun  out  1  sticky: a startOfFrame arrived while busy.

## Operation
- Reset: logX, logY all 0; state IDLE; idx 0; busy 0; done 0; overrun 0; load_pending 0.
- States: IDLE, LOAD, UPDATE. idx is a 4-bit counter 0..NUM_OF_LOGS-1.
- IDLE: if load or load_pending -> LOAD, idx=0, clear load_pending. Else if startOfFrame and !pause -> UPDATE, idx=0. Load has priority over startOfFrame in the same cycle; that startOfFrame is dropped, no overrun.
- LOAD: each cycle logX[idx] = {1'b0, start_offsetX[idx]}, logY[idx] = {1'b0, start_offsetY[idx]}; idx++. After idx=14 written -> IDLE, done pulse. A load clears overrun.
- UPDATE: each cycle updates log idx only; others hold. Direction: idx[0]=0 right, 1 left. Speed s = idx[1:0] + 1 (1..4 px).
  - Right: t = x + s (11-bit); logX = (t >= SCREEN_W) ? t - SCREEN_W : t.
  - Left: logX = (x < s) ? x + SCREEN_W - s : x - s.
  - After idx=14 -> IDLE, done pulse.
- While busy: startOfFrame sets overrun (regardless of pause); load sets load_pending, serviced at the next IDLE cycle.
- pause affects only new UPDATE passes; an in-progress pass completes.
- Asynchronous reset mid-pass aborts immediately to reset values.

## Timing
- Request sampled at edge E0: busy=1 from E0; log k written at edge E0+k+1; edge E0+15 writes log 14, returns to IDLE, drives busy=0 and done=1; done drops at E0+16.
- busy high exactly 15 cycles per pass; done 1 cycle.
- A pending load starts at the edge after done (E0+16).
- All outputs registered; no combinational path input->output.

## Test plan
- Reset: assert resetN=0 mid-pass -> all logX/logY 0, busy 0, done 0, overrun 0 immediately.
- Load: offsetX[0]=100, offsetY[0]=50, offsetX[14]=511, pulse load -> busy 15 cycles, done once, logX[0]=100, logY[0]=50, logX[14]=511.
- Move: after load (logX[0]=100, logX[1]=20), pulse startOfFrame -> logX[0]=101 (right,1), logX[1]=18 (left,2); log 1 changes one cycle after log 0.
- Wrap: logX[2]=638 -> 1 (right,3); logX[3]=2 -> 638 (left,4); logX[0]=639 -> 0.
- Pause/priority: pause=1 + startOfFrame -> no busy, no done, positions unchanged; load and startOfFrame same cycle -> LOAD only.
- Overrun/deferred load: startOfFrame and load both during UPDATE -> overrun=1, UPDATE finishes, LOAD starts next cycle, overrun cleared by that load.
